conv_acc_requant: RTL and testbench

Downstream consumer of the 8x8 Wallace-tree multiplier in the RepVGG accelerator datapath. Accepts a stream of signed 16-bit partial products, accumulates NPROD of them (one 3x3 kernel window) on top of a per-output bias, then requantizes to signed 8-bit with round-half-up arithmetic shift and saturation. The result is presented on a valid/ready output port to the activation/writeback stage.

---
 rtl/conv_acc_requant.sv | 106 ++++++++++
 tb/tb_conv_acc_requant.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/conv_acc_requant.sv
// Accumulates NPROD signed products on top of a bias, then requantizes to DWO bits
// (round-half-up shift, saturation). Define RELU_EN to clamp negative results to zero.
module conv_acc_requant #(
  parameter int DWP   = 16,
  parameter int DWA   = 24,
  parameter int NPROD = 9,
  parameter int DWO   = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [DWP-1:0] in_prod,
  input  logic [DWA-1:0] bias,
  input  logic [4:0]     shift,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DWO-1:0] out_data
);

  localparam int CW = (NPROD > 1) ? $clog2(NPROD) : 1;
  localparam logic signed [DWA:0] SAT_MAX = $signed((DWA+1)'((1 << (DWO-1)) - 1));
  localparam logic signed [DWA:0] SAT_MIN = -SAT_MAX - 1;

  typedef enum logic [1:0] {ST_ACC, ST_REQ, ST_OUT} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [DWA-1:0]  acc;
  logic [4:0]      shift_q;

  logic [DWA-1:0]        prod_ext;
  logic signed [DWA:0]   rnd;
  logic signed [DWA:0]   sum;
  logic signed [DWA:0]   r;
  logic [DWO-1:0]        sat_val;

  assign in_ready = (state == ST_ACC) && !clr;
  assign prod_ext = {{(DWA-DWP){in_prod[DWP-1]}}, in_prod};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    rnd = '0;
    if (shift_q != 5'd0) rnd = (DWA+1)'(1) << (shift_q - 5'd1);
    // One extra bit keeps the rounding add from wrapping near the positive limit.
    sum = $signed({acc[DWA-1], acc}) + rnd;
    r   = sum >>> shift_q;
    if (r > SAT_MAX)      sat_val = SAT_MAX[DWO-1:0];
    else if (r < SAT_MIN) sat_val = SAT_MIN[DWO-1:0];
    else                  sat_val = r[DWO-1:0];
`ifdef RELU_EN
    if (sat_val[DWO-1]) sat_val = '0;
`else
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_ACC;
      cnt       <= '0;
      acc       <= '0;
      shift_q   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (clr) begin
      state     <= ST_ACC;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_ACC: begin
          if (in_valid) begin
            if (cnt == '0) begin
              acc     <= bias + prod_ext;
              shift_q <= shift;
            end else begin
              acc <= acc + prod_ext;
            end
            if (cnt == CW'(NPROD-1)) begin
              cnt   <= '0;
              state <= ST_REQ;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        ST_REQ: begin
          out_data  <= sat_val;
          out_valid <= 1'b1;
          state     <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_ACC;
          end
        end
        default: state <= ST_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_acc_requant.sv
// Directed self-checking bench for conv_acc_requant (default NPROD=9, DWO=8).
module tb_conv_acc_requant;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_prod;
  logic [23:0] bias;
  logic [4:0]  shift;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;

  int vectors = 0;
  int miscompares = 0;

  conv_acc_requant dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod),
    .bias(bias), .shift(shift),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  // Offers n beats; counts beats where the DUT was not ready. Ends on a negedge.
  task automatic feed(input int n, input logic [15:0] p, input logic [23:0] b,
                      input logic [4:0] s, output int stalls);
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_prod = p; bias = b; shift = s;
      if (in_ready !== 1'b1) stalls++;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Waits (bounded) on negedges until out_valid is seen.
  task automatic wait_result(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vectors++; if (out_data !== 8'h00) begin miscompares++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int st; bit ok;
    feed(9, 16'sd100, 24'sd0, 5'd4, st);
    vectors++; if (st != 0) begin miscompares++; $display("FAIL basic_stalls: got %0d want 0", st); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_latency_req: got out_valid %b want 0", out_valid); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL basic_in_ready_req: got %b want 0", in_ready); end
    @(negedge clk);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL basic_latency_out: got out_valid %b want 1", out_valid); end
    wait_result(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL basic_timeout: got no out_valid want out_valid"); end
    vectors++; if (out_data !== 8'd56) begin miscompares++; $display("FAIL basic_data: got %h want %h", out_data, 8'd56); end
    take();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_drop_valid: got %b want 0", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL basic_back_to_acc: got %b want 1", in_ready); end
  endtask

  task automatic test_saturation();
    int st; bit ok;
    logic [7:0] exp_neg;
`ifdef RELU_EN
    exp_neg = 8'h00;
`else
    exp_neg = 8'h80;
`endif
    feed(9, -16'sd1000, 24'sd0, 5'd4, st);
    wait_result(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL sat_neg_timeout: got no out_valid want out_valid"); end
    vectors++; if (out_data !== exp_neg) begin miscompares++; $display("FAIL sat_neg_data: got %h want %h", out_data, exp_neg); end
    take();
    feed(9, 16'sd32767, 24'sd0, 5'd0, st);
    wait_result(ok);
    vectors++; if (out_data !== 8'h7f) begin miscompares++; $display("FAIL sat_pos_data: got %h want 7f", out_data); end
    take();
    feed(9, 16'sd32767, -24'sd294903, 5'd0, st);
    wait_result(ok);
    vectors++; if (out_data !== 8'h00) begin miscompares++; $display("FAIL bias_cancel_data: got %h want 00", out_data); end
    take();
  endtask

  task automatic test_backpressure();
    int st; bit ok;
    logic [7:0] exp_next;
`ifdef RELU_EN
    exp_next = 8'h00;
`else
    exp_next = 8'hf3;
`endif
    // acc = 9*10 + 5 = 95 ; (95 + 2) >>> 2 = 24
    feed(9, 16'sd10, 24'sd5, 5'd2, st);
    wait_result(ok);
    in_valid = 1'b1; in_prod = 16'sd77; bias = 24'sd0; shift = 5'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid[%0d]: got %b want 1", i, out_valid); end
      vectors++; if (out_data !== 8'd24) begin miscompares++; $display("FAIL bp_data[%0d]: got %h want %h", i, out_data, 8'd24); end
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
    end
    in_valid = 1'b0;
    take();
    // acc = -27 ; (-27 + 1) >>> 1 = -13
    feed(9, -16'sd3, 24'sd0, 5'd1, st);
    vectors++; if (st != 0) begin miscompares++; $display("FAIL bp_next_stalls: got %0d want 0", st); end
    wait_result(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL bp_next_timeout: got no out_valid want out_valid"); end
    vectors++; if (out_data !== exp_next) begin miscompares++; $display("FAIL bp_next_data: got %h want %h", out_data, exp_next); end
    take();
  endtask

  task automatic test_clr();
    int st; bit ok;
    feed(4, 16'sd50, 24'sd0, 5'd0, st);
    clr = 1'b1; in_valid = 1'b1; in_prod = 16'sd99;
    #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL clr_in_ready: got %b want 0", in_ready); end
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL clr_out_valid: got %b want 0", out_valid); end
    // Exactly 9 fresh beats must be needed: out_valid must not rise mid-feed.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i > 0) begin
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL clr_stale[%0d]: got %b want 0", i, out_valid); end
      end
      in_valid = 1'b1; in_prod = 16'sd1; bias = 24'sd7; shift = 5'd1;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    wait_result(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL clr_timeout: got no out_valid want out_valid"); end
    vectors++; if (out_data !== 8'd8) begin miscompares++; $display("FAIL clr_data: got %h want %h", out_data, 8'd8); end
    take();
  endtask

  task automatic test_reset_mid();
    int st; bit ok;
    feed(9, 16'sd100, 24'sd0, 5'd4, st);
    wait_result(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL rst_pre_timeout: got no out_valid want out_valid"); end
    rst_n = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_valid: got %b want 0", out_valid); end
    vectors++; if (out_data !== 8'h00) begin miscompares++; $display("FAIL rst_mid_data: got %h want 00", out_data); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_mid_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    // acc = 18 - 2 = 16 ; (16 + 2) >>> 2 = 4
    feed(9, 16'sd2, -24'sd2, 5'd2, st);
    wait_result(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL rst_post_timeout: got no out_valid want out_valid"); end
    vectors++; if (out_data !== 8'd4) begin miscompares++; $display("FAIL rst_post_data: got %h want %h", out_data, 8'd4); end
    take();
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_prod = '0;
    bias = '0; shift = '0; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_clr();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
